// File: rtl/link_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one credit-based link among N_REQ sources.
// Latency: winner registered 1 cycle after request; first flit can move that cycle; 1 idle bubble per packet.
// Backpressure: link cr_i passes straight to the owner's req_cr_o; losers and idle sources see req_cr_o=0.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_tx_i/_data_i/_eop_i  per-source flit valid, flit (source i at [i*FLIT_WIDTH +: FLIT_WIDTH]), last flit
//   req_cr_o                 per-source credit / ready
//   tx_o, data_o, eop_o      link flit valid, flit, last flit
//   cr_i                     link credit / ready from downstream
//   grant_o                  one-hot current owner, 0 when idle
//   hang_o                   sticky stall watchdog flag
//
// Optional feature macro: LINK_ARB_WDOG_EN enables the stall watchdog driving hang_o;
// without it hang_o is tied to 0.
`timescale 1ns/1ps

module link_rr_arbiter #(
    parameter int N_REQ       = 4,
    parameter int FLIT_WIDTH  = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_REQ-1:0]            req_tx_i,
    input  logic [N_REQ*FLIT_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]            req_eop_i,
    output logic [N_REQ-1:0]            req_cr_o,
    output logic                        tx_o,
    output logic [FLIT_WIDTH-1:0]       data_o,
    output logic                        eop_o,
    input  logic                        cr_i,
    output logic [N_REQ-1:0]            grant_o,
    output logic                        hang_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               handshake;
    logic               eop_xfer;

    // Scan starting at rr_ptr and wrapping, first requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!win_found && req_tx_i[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    // Link side is a pure pass-through of the owner while BUSY; everything is quiet in IDLE.
    always_comb begin
        tx_o     = 1'b0;
        data_o   = '0;
        eop_o    = 1'b0;
        req_cr_o = '0;
        if (state_q == ST_BUSY) begin
            tx_o              = req_tx_i[owner_q];
            data_o            = req_data_i[int'(owner_q)*FLIT_WIDTH +: FLIT_WIDTH];
            eop_o             = req_eop_i[owner_q];
            req_cr_o[owner_q] = cr_i;
        end
    end

    assign handshake = tx_o && cr_i;
    assign eop_xfer  = handshake && eop_o;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_BUSY;
                    owner_d = win_idx;
                    grant_d = N_REQ'(1) << win_idx;
                end
            end
            ST_BUSY: begin
                // Grant is held until the owner's EOP flit actually transfers,
                // regardless of tx gaps or credit stalls.
                if (eop_xfer) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_o = grant_q;

`ifdef LINK_ARB_WDOG_EN
    logic [31:0] stall_cnt_q;
    logic        hang_q;

    // Counts consecutive BUSY cycles without a handshake; saturates at the threshold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            hang_q      <= 1'b0;
        end else begin
            if (state_q != ST_BUSY || handshake) begin
                stall_cnt_q <= '0;
            end else if (stall_cnt_q != 32'(WDOG_CYCLES)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
                if (stall_cnt_q + 32'd1 == 32'(WDOG_CYCLES) && !hang_q) begin
                    hang_q <= 1'b1;
`ifndef SYNTHESIS
                    $display("[%7.3f] [ARB] link hang, owner %0d", $realtime / 1.0e6, owner_q);
`endif
                end
            end
        end
    end

    assign hang_o = hang_q;
`else
    assign hang_o = 1'b0;
`endif

endmodule

// File: tb/tb_link_rr_arbiter.sv
`timescale 1ns/1ps

module tb_link_rr_arbiter;

    localparam int N  = 4;
    localparam int FW = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req_tx_i;
    logic [N*FW-1:0] req_data_i;
    logic [N-1:0]    req_eop_i;
    logic [N-1:0]    req_cr_o;
    logic            tx_o;
    logic [FW-1:0]   data_o;
    logic            eop_o;
    logic            cr_i;
    logic [N-1:0]    grant_o;
    logic            hang_o;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk_i = ~clk_i;

    link_rr_arbiter #(.N_REQ(N), .FLIT_WIDTH(FW), .WDOG_CYCLES(16)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_tx_i   (req_tx_i),
        .req_data_i (req_data_i),
        .req_eop_i  (req_eop_i),
        .req_cr_o   (req_cr_o),
        .tx_o       (tx_o),
        .data_o     (data_o),
        .eop_o      (eop_o),
        .cr_i       (cr_i),
        .grant_o    (grant_o),
        .hang_o     (hang_o)
    );

    // Advance one clock; outputs are observed 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [FW-1:0] val);
        req_data_i[idx*FW +: FW] = val;
    endtask

    task automatic apply_reset();
        req_tx_i   = '0;
        req_eop_i  = '0;
        req_data_i = '0;
        cr_i       = 1'b0;
        rst_ni     = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        req_tx_i   = 4'b1111;
        req_eop_i  = 4'b1111;
        req_data_i = {N*FW{1'b1}};
        cr_i       = 1'b1;
        rst_ni     = 1'b0;
        tick();
        tick();
        chk_cnt++; if (grant_o !== 4'b0000) begin err_cnt++; $display("FAIL reset_grant: got %b expected 0000", grant_o); end
        chk_cnt++; if (tx_o !== 1'b0) begin err_cnt++; $display("FAIL reset_tx: got %b expected 0", tx_o); end
        chk_cnt++; if (data_o !== 32'h0) begin err_cnt++; $display("FAIL reset_data: got %h expected 0", data_o); end
        chk_cnt++; if (eop_o !== 1'b0) begin err_cnt++; $display("FAIL reset_eop: got %b expected 0", eop_o); end
        chk_cnt++; if (req_cr_o !== 4'b0000) begin err_cnt++; $display("FAIL reset_req_cr: got %b expected 0000", req_cr_o); end
        chk_cnt++; if (hang_o !== 1'b0) begin err_cnt++; $display("FAIL reset_hang: got %b expected 0", hang_o); end
    endtask

    task automatic test_single_source();
        logic [FW-1:0] flits [3];
        flits[0] = 32'hA000_0001;
        flits[1] = 32'hA000_0002;
        flits[2] = 32'hA000_0003;
        apply_reset();
        req_tx_i = 4'b0001;
        cr_i     = 1'b1;
        set_data(0, flits[0]);
        #1;
        chk_cnt++; if (req_cr_o !== 4'b0000 || tx_o !== 1'b0) begin err_cnt++; $display("FAIL idle_no_credit: got cr=%b tx=%b expected 0000/0", req_cr_o, tx_o); end
        for (int f = 0; f < 3; f++) begin
            tick();
            set_data(0, flits[f]);
            req_eop_i = (f == 2) ? 4'b0001 : 4'b0000;
            #1;
            chk_cnt++; if (grant_o !== 4'b0001) begin err_cnt++; $display("FAIL single_grant[%0d]: got %b expected 0001", f, grant_o); end
            chk_cnt++; if (data_o !== flits[f] || tx_o !== 1'b1) begin err_cnt++; $display("FAIL single_flit[%0d]: got %h/%b expected %h/1", f, data_o, tx_o, flits[f]); end
            chk_cnt++; if (req_cr_o !== 4'b0001) begin err_cnt++; $display("FAIL single_cr[%0d]: got %b expected 0001", f, req_cr_o); end
            chk_cnt++; if (eop_o !== (f == 2)) begin err_cnt++; $display("FAIL single_eop[%0d]: got %b expected %b", f, eop_o, (f == 2)); end
        end
        tick();
        req_tx_i  = '0;
        req_eop_i = '0;
        #1;
        chk_cnt++; if (grant_o !== 4'b0000 || tx_o !== 1'b0) begin err_cnt++; $display("FAIL single_idle: got grant=%b tx=%b expected 0000/0", grant_o, tx_o); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_grant [5];
        logic [FW-1:0] exp_data [5];
        exp_grant[0] = 4'b0001; exp_grant[1] = 4'b0010; exp_grant[2] = 4'b0100;
        exp_grant[3] = 4'b1000; exp_grant[4] = 4'b0001;
        exp_data[0] = 32'hB000_0000; exp_data[1] = 32'hB000_0001; exp_data[2] = 32'hB000_0002;
        exp_data[3] = 32'hB000_0003; exp_data[4] = 32'hB000_0000;
        apply_reset();
        for (int i = 0; i < N; i++) set_data(i, 32'hB000_0000 + 32'(i));
        req_tx_i  = 4'b1111;
        req_eop_i = 4'b1111;
        cr_i      = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_cnt++; if (grant_o !== exp_grant[k]) begin err_cnt++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, grant_o, exp_grant[k]); end
            chk_cnt++; if (data_o !== exp_data[k] || eop_o !== 1'b1) begin err_cnt++; $display("FAIL rr_data[%0d]: got %h/%b expected %h/1", k, data_o, eop_o, exp_data[k]); end
            tick();
            chk_cnt++; if (grant_o !== 4'b0000) begin err_cnt++; $display("FAIL rr_bubble[%0d]: got %b expected 0000", k, grant_o); end
        end
        req_tx_i  = '0;
        req_eop_i = '0;
    endtask

    task automatic test_credit_stall();
        apply_reset();
        req_tx_i = 4'b0100;
        set_data(2, 32'hC000_0001);
        cr_i = 1'b1;
        tick();
        tick();
        set_data(2, 32'hC000_0002);
        cr_i     = 1'b0;
        req_tx_i = 4'b0101;
        #1;
        for (int s = 0; s < 10; s++) begin
            tick();
            chk_cnt++; if (grant_o !== 4'b0100) begin err_cnt++; $display("FAIL stall_grant[%0d]: got %b expected 0100", s, grant_o); end
            chk_cnt++; if (req_cr_o !== 4'b0000) begin err_cnt++; $display("FAIL stall_cr[%0d]: got %b expected 0000", s, req_cr_o); end
            chk_cnt++; if (data_o !== 32'hC000_0002) begin err_cnt++; $display("FAIL stall_data[%0d]: got %h expected c0000002", s, data_o); end
        end
        cr_i      = 1'b1;
        req_eop_i = 4'b0100;
        #1;
        chk_cnt++; if (req_cr_o !== 4'b0100 || eop_o !== 1'b1) begin err_cnt++; $display("FAIL stall_release: got cr=%b eop=%b expected 0100/1", req_cr_o, eop_o); end
        tick();
        req_tx_i  = '0;
        req_eop_i = '0;
        chk_cnt++; if (grant_o !== 4'b0000) begin err_cnt++; $display("FAIL stall_end: got %b expected 0000", grant_o); end
        chk_cnt++; if (hang_o !== 1'b0) begin err_cnt++; $display("FAIL stall_nohang: got %b expected 0", hang_o); end
    endtask

    task automatic test_owner_gap();
        apply_reset();
        // One-flit packet from source 0 moves rr_ptr to 1.
        req_tx_i  = 4'b0001;
        req_eop_i = 4'b0001;
        cr_i      = 1'b1;
        tick();
        tick();
        req_tx_i  = 4'b0011;
        req_eop_i = 4'b0000;
        set_data(1, 32'hD000_0001);
        #1;
        tick();
        chk_cnt++; if (grant_o !== 4'b0010) begin err_cnt++; $display("FAIL gap_grant: got %b expected 0010", grant_o); end
        req_tx_i = 4'b0001;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk_cnt++; if (grant_o !== 4'b0010 || tx_o !== 1'b0 || req_cr_o[0] !== 1'b0) begin err_cnt++; $display("FAIL gap_hold[%0d]: got grant=%b tx=%b cr0=%b expected 0010/0/0", s, grant_o, tx_o, req_cr_o[0]); end
        end
        req_tx_i  = 4'b0011;
        req_eop_i = 4'b0010;
        set_data(1, 32'hD000_0002);
        #1;
        chk_cnt++; if (data_o !== 32'hD000_0002 || eop_o !== 1'b1) begin err_cnt++; $display("FAIL gap_eop: got %h/%b expected d0000002/1", data_o, eop_o); end
        tick();
        req_tx_i  = 4'b0001;
        req_eop_i = 4'b0000;
        chk_cnt++; if (grant_o !== 4'b0000) begin err_cnt++; $display("FAIL gap_idle: got %b expected 0000", grant_o); end
        tick();
        chk_cnt++; if (grant_o !== 4'b0001) begin err_cnt++; $display("FAIL gap_wrap: got %b expected 0001", grant_o); end
        req_tx_i = '0;
    endtask

    task automatic test_reset_midpacket();
        apply_reset();
        // Move rr_ptr away from 0 first so the post-reset grant proves it was cleared.
        req_tx_i  = 4'b0001;
        req_eop_i = 4'b0001;
        cr_i      = 1'b1;
        tick();
        tick();
        req_tx_i  = 4'b0010;
        req_eop_i = 4'b0000;
        set_data(1, 32'hE000_0001);
        tick();
        chk_cnt++; if (grant_o !== 4'b0010) begin err_cnt++; $display("FAIL rst_pre_grant: got %b expected 0010", grant_o); end
        rst_ni = 1'b0;
        #1;
        chk_cnt++; if (grant_o !== 4'b0000 || tx_o !== 1'b0 || req_cr_o !== 4'b0000 || data_o !== 32'h0 || eop_o !== 1'b0) begin
            err_cnt++; $display("FAIL rst_async: got grant=%b tx=%b cr=%b data=%h eop=%b expected all 0", grant_o, tx_o, req_cr_o, data_o, eop_o);
        end
        #2;
        rst_ni    = 1'b1;
        req_tx_i  = 4'b1001;
        tick();
        chk_cnt++; if (grant_o !== 4'b0001) begin err_cnt++; $display("FAIL rst_rrptr: got %b expected 0001", grant_o); end
        req_tx_i = '0;
    endtask

    task automatic test_watchdog();
        apply_reset();
        req_tx_i = 4'b0001;
        cr_i     = 1'b0;
        tick();
`ifdef LINK_ARB_WDOG_EN
        for (int s = 0; s < 15; s++) tick();
        chk_cnt++; if (hang_o !== 1'b0) begin err_cnt++; $display("FAIL wdog_early: got %b expected 0", hang_o); end
        tick();
        chk_cnt++; if (hang_o !== 1'b1) begin err_cnt++; $display("FAIL wdog_rise: got %b expected 1", hang_o); end
`else
        for (int s = 0; s < 20; s++) tick();
        chk_cnt++; if (hang_o !== 1'b0) begin err_cnt++; $display("FAIL wdog_tied: got %b expected 0", hang_o); end
`endif
        chk_cnt++; if (grant_o !== 4'b0001) begin err_cnt++; $display("FAIL wdog_grant: got %b expected 0001", grant_o); end
        cr_i      = 1'b1;
        req_eop_i = 4'b0001;
        tick();
        req_tx_i  = '0;
        req_eop_i = '0;
        tick();
`ifdef LINK_ARB_WDOG_EN
        chk_cnt++; if (hang_o !== 1'b1) begin err_cnt++; $display("FAIL wdog_sticky: got %b expected 1", hang_o); end
`else
        chk_cnt++; if (hang_o !== 1'b0) begin err_cnt++; $display("FAIL wdog_tied_end: got %b expected 0", hang_o); end
`endif
        chk_cnt++; if (grant_o !== 4'b0000) begin err_cnt++; $display("FAIL wdog_released: got %b expected 0000", grant_o); end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_back_to_back();
        test_credit_stall();
        test_owner_gap();
        test_reset_midpacket();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
